data_sram_slave: RTL and testbench

DATA_SRAM_SLAVE -- requirements
Module: data_sram_slave

---
 rtl/data_sram_slave_if.sv | 25 ++
 rtl/data_sram_slave.sv | 109 ++++++++++
 tb/tb_data_sram_slave.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_sram_slave_if.sv
// Master-side request/response bus of the data SRAM slave.
// The master drives the request fields; the slave returns addrok/dataok/rdata.
interface data_sram_slave_if;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addrok;
  logic        data_sram_dataok;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
           data_sram_wstrb, data_sram_wdata,
    input  data_sram_addrok, data_sram_dataok, data_sram_rdata
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
           data_sram_wstrb, data_sram_wdata,
    output data_sram_addrok, data_sram_dataok, data_sram_rdata
  );
endinterface

// File: rtl/data_sram_slave.sv
// Pipelined SRAM slave: accepts up to MAX_OUT requests, issues them to a synchronous
// RAM in order, and answers each with one dataok pulse after RESP_DELAY extra cycles.
module data_sram_slave #(
  parameter int ADDR_W     = 16,
  parameter int MAX_OUT    = 2,
  parameter int RESP_DELAY = 0
) (
  input  logic              clk,
  input  logic              reset,
  data_sram_slave_if.slave  bus,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);
  localparam int              PTR_W    = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [2:0]      MAX_CNT  = 3'(MAX_OUT);
  localparam logic [2:0]      DLY      = 3'(RESP_DELAY);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUT - 1);

  logic             accept;
  logic             pop;
  logic [2:0]       out_q, out_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [PTR_W-1:0] wptr_q, rptr_q, fill_idx_q;
  logic             fill_q;
  logic             dataok_q;
  logic [31:0]      rdata_q;
  logic [31:0]      head_data;
  logic [31:0]      data_q [MAX_OUT];
  logic             wr_q   [MAX_OUT];
  logic [2:0]       dly_q  [MAX_OUT];
  logic             unused_bits;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Acceptance only looks at the registered outstanding count, never at dataok.
  assign accept    = bus.data_sram_req && (out_q < MAX_CNT) && !reset;
  assign bus.data_sram_addrok = accept;
  assign ram_en    = accept;
  assign ram_we    = (accept && bus.data_sram_wr) ? bus.data_sram_wstrb : 4'b0000;
  assign ram_addr  = bus.data_sram_addr[ADDR_W+1:2];
  assign ram_wdata = bus.data_sram_wdata;
  assign unused_bits = ^{bus.data_sram_size, bus.data_sram_addr[1:0],
                         bus.data_sram_addr[31:ADDR_W+2]};

  assign bus.data_sram_dataok = dataok_q && !reset;
  assign bus.data_sram_rdata  = reset ? 32'h0 : rdata_q;

  // Entries are allocated at accept; their data lands one cycle later from the RAM,
  // so a head still waiting for its fill takes ram_rdata directly.
  assign pop = (cnt_q != 3'd0) && (dly_q[rptr_q] == 3'd0);

  always_comb begin
    head_data = data_q[rptr_q];
    if (fill_q && (fill_idx_q == rptr_q)) begin
      head_data = wr_q[rptr_q] ? 32'h0 : ram_rdata;
    end
  end

  always_comb begin
    out_d = out_q + {2'b00, accept} - {2'b00, dataok_q};
    cnt_d = cnt_q + {2'b00, accept} - {2'b00, pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q      <= '0;
      cnt_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      fill_q     <= 1'b0;
      fill_idx_q <= '0;
      dataok_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      out_q      <= out_d;
      cnt_q      <= cnt_d;
      fill_q     <= accept;
      fill_idx_q <= wptr_q;
      dataok_q   <= pop;
      if (accept) wptr_q <= next_ptr(wptr_q);
      if (pop) begin
        rptr_q  <= next_ptr(rptr_q);
        rdata_q <= head_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_OUT; i++) begin
      if (reset) begin
        dly_q[i] <= '0;
      end else if (accept && (wptr_q == PTR_W'(i))) begin
        dly_q[i] <= DLY;
      end else if (dly_q[i] != 3'd0) begin
        dly_q[i] <= dly_q[i] - 3'd1;
      end
      if (accept && (wptr_q == PTR_W'(i))) wr_q[i] <= bus.data_sram_wr;
      if (fill_q && (fill_idx_q == PTR_W'(i))) data_q[i] <= wr_q[i] ? 32'h0 : ram_rdata;
    end
  end

  a_no_queue_overflow: assert property (@(posedge clk) disable iff (reset)
                                        !(accept && (cnt_q == MAX_CNT)));
endmodule

// File: tb/tb_data_sram_slave.sv
// Two slaves (MAX_OUT=2/RESP_DELAY=0 and MAX_OUT=3/RESP_DELAY=3) share one stimulus
// stream and are checked against a transaction-level timing and memory model.
module tb_data_sram_slave;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0, wr = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  wstrb = '0;

  logic        addrok_w [2];
  logic        dataok_w [2];
  logic [31:0] rdata_w  [2];
  logic        ram_en_w [2];
  logic [3:0]  ram_we_w [2];
  logic [15:0] ram_addr_w [2];
  logic [31:0] ram_wdata_w [2];

  always #5 clk = ~clk;

  function automatic int mo(input int k);
    return (k == 0) ? 2 : 3;
  endfunction
  function automatic int dl(input int k);
    return (k == 0) ? 0 : 3;
  endfunction
  function automatic logic [31:0] init_word(input int i);
    return (i == 16) ? 32'hDEADBEEF : {8'(i), 8'hA5, 8'(i * 3), 8'h3C};
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    data_sram_slave_if bus ();
    logic [31:0] mem [65536];
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [15:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;

    assign bus.data_sram_req   = req;
    assign bus.data_sram_wr    = wr;
    assign bus.data_sram_size  = size;
    assign bus.data_sram_addr  = addr;
    assign bus.data_sram_wstrb = wstrb;
    assign bus.data_sram_wdata = wdata;

    data_sram_slave #(.ADDR_W(16), .MAX_OUT(gi == 0 ? 2 : 3), .RESP_DELAY(gi == 0 ? 0 : 3)) dut (
      .clk(clk), .reset(reset), .bus(bus),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial for (int i = 0; i < 64; i++) mem[i] = init_word(i);

    always @(posedge clk) begin
      if (ram_en) begin
        ram_rdata <= mem[ram_addr];
        for (int b = 0; b < 4; b++)
          if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end

    assign addrok_w[gi]    = bus.data_sram_addrok;
    assign dataok_w[gi]    = bus.data_sram_dataok;
    assign rdata_w[gi]     = bus.data_sram_rdata;
    assign ram_en_w[gi]    = ram_en;
    assign ram_we_w[gi]    = ram_we;
    assign ram_addr_w[gi]  = ram_addr;
    assign ram_wdata_w[gi] = ram_wdata;
  end

  int n_checks = 0, n_errors = 0, cyc = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: memory image plus queue of (response cycle, data) per slave.
  logic [31:0] ref_mem [2][64];
  int          q_cyc [2][16];
  logic [31:0] q_dat [2][16];
  int          qh [2], qn [2], outst [2], last_resp [2];
  logic [31:0] last_rd [2];
  int          dok_log0 [$], dok_log1 [$];
  logic [31:0] last_dok_dat0;

  task automatic do_cycle(input logic r, input logic w, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] d, input logic rst);
    @(posedge clk);
    #1;
    req = r; wr = w; addr = a; wstrb = s; wdata = d; reset = rst;
    size = 2'($urandom_range(0, 2));
    cyc++;
    #3;
    for (int k = 0; k < 2; k++) begin
      logic acc, dok;
      int rc, wi, tl;
      logic [31:0] dat;
      acc = r && !rst && (outst[k] < mo(k));
      dok = !rst && (qn[k] > 0) && (q_cyc[k][qh[k]] == cyc);
      if (rst) begin
        qn[k] = 0; outst[k] = 0; last_rd[k] = '0; last_resp[k] = 0;
      end
      chk_eq($sformatf("d%0d addrok", k), addrok_w[k], acc);
      chk_eq($sformatf("d%0d ram_en", k), ram_en_w[k], acc);
      chk_eq($sformatf("d%0d ram_we", k), ram_we_w[k], (acc && w) ? s : 4'b0000);
      if (acc) begin
        chk_eq($sformatf("d%0d ram_addr", k), ram_addr_w[k], a[17:2]);
        chk_eq($sformatf("d%0d ram_wdata", k), ram_wdata_w[k], d);
      end
      chk_eq($sformatf("d%0d dataok", k), dataok_w[k], dok);
      if (dok) begin
        last_rd[k] = q_dat[k][qh[k]];
        qh[k] = (qh[k] + 1) % 16;
        qn[k]--;
        outst[k]--;
      end
      chk_eq($sformatf("d%0d rdata", k), rdata_w[k], last_rd[k]);
      if (dataok_w[k]) begin
        if (k == 0) begin dok_log0.push_back(cyc); last_dok_dat0 = rdata_w[0]; end
        else dok_log1.push_back(cyc);
      end
      if (acc) begin
        wi = int'(a[7:2]);
        rc = cyc + 2 + dl(k);
        if (rc <= last_resp[k]) rc = last_resp[k] + 1;
        last_resp[k] = rc;
        dat = w ? 32'h0 : ref_mem[k][wi];
        if (w) for (int b = 0; b < 4; b++)
          if (s[b]) ref_mem[k][wi][8*b +: 8] = d[8*b +: 8];
        tl = (qh[k] + qn[k]) % 16;
        q_cyc[k][tl] = rc;
        q_dat[k][tl] = dat;
        qn[k]++;
        outst[k]++;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) do_cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
  endtask

  initial begin
    int t;
    logic [8:0] pat;
    int n_acc, n_dok;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 64; i++) ref_mem[k][i] = init_word(i);
      qh[k] = 0; qn[k] = 0; outst[k] = 0; last_resp[k] = 0; last_rd[k] = '0;
    end
    repeat (3) do_cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    idle(2);

    // Single read of word 0x10; slow slave answers three cycles later.
    dok_log0.delete(); dok_log1.delete();
    do_cycle(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 1'b0);
    t = cyc;
    idle(10);
    chk_eq("single_read_count", dok_log0.size(), 1);
    if (dok_log0.size() > 0) chk_eq("single_read_cycle", dok_log0[0], t + 2);
    chk_eq("single_read_data", last_dok_dat0, 32'hDEADBEEF);
    if (dok_log1.size() > 0) chk_eq("delay3_cycle", dok_log1[0], t + 5);
    else chk_eq("delay3_count", dok_log1.size(), 1);

    // Back-to-back reads with RESP_DELAY=3.
    dok_log1.delete();
    do_cycle(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 1'b0);
    t = cyc;
    do_cycle(1'b1, 1'b0, 32'h44, 4'h0, 32'h0, 1'b0);
    idle(12);
    chk_eq("delay3_b2b_count", dok_log1.size(), 2);
    if (dok_log1.size() == 2) begin
      chk_eq("delay3_first", dok_log1[0], t + 5);
      chk_eq("delay3_second", dok_log1[1], t + 6);
    end

    // Byte write into a known word, then read back.
    do_cycle(1'b1, 1'b1, 32'h40, 4'hF, 32'h11223344, 1'b0);
    idle(8);
    do_cycle(1'b1, 1'b1, 32'h41, 4'b0010, 32'h0000AB00, 1'b0);
    idle(8);
    chk_eq("write_resp_rdata", last_dok_dat0, 32'h0);
    do_cycle(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 1'b0);
    idle(8);
    chk_eq("byte_write_readback", last_dok_dat0, 32'h1122AB44);

    // Zero-strobe write must leave RAM untouched yet still be answered.
    dok_log0.delete();
    do_cycle(1'b1, 1'b1, 32'h44, 4'h0, 32'hFFFFFFFF, 1'b0);
    idle(8);
    chk_eq("zero_strobe_dataok", dok_log0.size(), 1);
    chk_eq("zero_strobe_ram", g_dut[0].mem[17], init_word(17));
    do_cycle(1'b1, 1'b0, 32'h44, 4'h0, 32'h0, 1'b0);
    idle(8);

    // Request held high: acceptance throttled by outstanding limit.
    pat = '0; n_acc = 0; dok_log0.delete();
    for (int i = 0; i < 9; i++) begin
      do_cycle(1'b1, 1'b0, 32'($urandom_range(0, 255)), 4'h0, 32'h0, 1'b0);
      pat = {pat[7:0], addrok_w[0]};
      if (addrok_w[0]) n_acc++;
    end
    idle(10);
    n_dok = dok_log0.size();
    chk_eq("backpressure_pattern", 32'(pat), 32'(9'b110110110));
    chk_eq("backpressure_dok_vs_acc", n_dok, n_acc);

    // Reset right after an accept discards the pending response.
    do_cycle(1'b1, 1'b0, 32'h48, 4'h0, 32'h0, 1'b0);
    do_cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    dok_log0.delete(); dok_log1.delete();
    idle(10);
    chk_eq("reset_discard_d0", dok_log0.size(), 0);
    chk_eq("reset_discard_d1", dok_log1.size(), 0);
    do_cycle(1'b1, 1'b0, 32'h48, 4'h0, 32'h0, 1'b0);
    t = cyc;
    idle(3);
    chk_eq("post_reset_count", dok_log0.size(), 1);
    if (dok_log0.size() > 0) chk_eq("post_reset_cycle", dok_log0[0], t + 2);
    idle(6);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      do_cycle(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 4),
               32'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), $urandom,
               1'($urandom_range(0, 99) == 0));
    end
    idle(15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
